// File: rtl/mips_pkg.sv
// mips_pkg: shared constants for the multicycle MIPS control path.
// Holds opcode values, alu_op / pc_src / alu_src_b encodings and the
// main-control state enumeration.
package mips_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned STATE_W = 4;

    // Supported opcodes (IR[31:26])
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    // alu_op encodings consumed by the ALU-control decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // pc_src encodings
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // alu_src_b encodings
    localparam logic [1:0] ALUSRCB_B       = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: control <-> datapath/memory signal bundle.
// master: the control FSM (takes op/zero/mem_ready, drives selects/enables).
// slave : the datapath side (drives op/zero/mem_ready, takes controls).
interface multicycle_control_if;
    import mips_pkg::*;

    logic [OP_W-1:0] op;
    logic            zero;
    logic            mem_ready;

    logic            mem_req;
    logic            mem_write;
    logic            iord;
    logic            ir_write;
    logic            reg_write;
    logic            reg_dst;
    logic            mem_to_reg;
    logic            alu_src_a;
    logic [1:0]      alu_src_b;
    logic [1:0]      alu_op;
    logic [1:0]      pc_src;
    logic            pc_en;
    logic            instr_done;
    logic            illegal_op;

    modport master (
        input  op, zero, mem_ready,
        output mem_req, mem_write, iord, ir_write, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, pc_en,
               instr_done, illegal_op
    );

    modport slave (
        output op, zero, mem_ready,
        input  mem_req, mem_write, iord, ir_write, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, pc_en,
               instr_done, illegal_op
    );

endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM of the multicycle MIPS datapath.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous active-high reset
//   bus   - multicycle_control_if.master (op/zero/mem_ready in,
//           mux selects, write enables and status pulses out)
// Outputs are a Moore decode of the state, except mem_ready gating the
// memory-state enables and zero gating pc_en in BEQEX.
module multicycle_control
    import mips_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);

    state_t r_state;
    state_t w_next;
    logic   r_is_sw;      // lw/sw choice latched in DECODE so op is only sampled there
    logic   w_is_sw_next;

    logic       w_mem_req, w_mem_write, w_iord, w_ir_write, w_reg_write;
    logic       w_reg_dst, w_mem_to_reg, w_alu_src_a;
    logic [1:0] w_alu_src_b, w_alu_op, w_pc_src;
    logic       w_pc_write, w_branch, w_instr_done, w_illegal_op;

    // Next-state logic
    always_comb begin
        w_next       = r_state;
        w_is_sw_next = r_is_sw;
        unique case (r_state)
            S_FETCH:   if (bus.mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                w_is_sw_next = (bus.op == OP_SW);
                case (bus.op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_RTYPEEX;
                    OP_BEQ:       w_next = S_BEQEX;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JEX;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEMADR:  w_next = r_is_sw ? S_MEMWR : S_MEMRD;
            S_MEMRD:   if (bus.mem_ready) w_next = S_MEMWB;
            S_MEMWR:   if (bus.mem_ready) w_next = S_FETCH;
            S_RTYPEEX: w_next = S_RTYPEWB;
            S_ADDIEX:  w_next = S_ADDIWB;
            default:   w_next = S_FETCH;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_is_sw <= 1'b0;
        end else begin
            r_state <= w_next;
            r_is_sw <= w_is_sw_next;
        end
    end

    // Output decoder
    always_comb begin
        w_mem_req    = 1'b0;
        w_mem_write  = 1'b0;
        w_iord       = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_reg_dst    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_alu_src_a  = 1'b0;
        w_alu_src_b  = ALUSRCB_B;
        w_alu_op     = ALUOP_ADD;
        w_pc_src     = PCSRC_ALU;
        w_pc_write   = 1'b0;
        w_branch     = 1'b0;
        w_instr_done = 1'b0;
        w_illegal_op = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                w_mem_req   = 1'b1;
                w_alu_src_b = ALUSRCB_FOUR;
                w_ir_write  = bus.mem_ready;
                w_pc_write  = bus.mem_ready;
            end
            S_DECODE: begin
                w_alu_src_b  = ALUSRCB_IMM_SH2;
                w_illegal_op = !(bus.op inside {OP_RTYPE, OP_LW, OP_SW,
                                                OP_BEQ, OP_ADDI, OP_J});
            end
            S_MEMADR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = ALUSRCB_IMM;
            end
            S_MEMRD: begin
                w_mem_req = 1'b1;
                w_iord    = 1'b1;
            end
            S_MEMWB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
                w_instr_done = 1'b1;
            end
            S_MEMWR: begin
                w_mem_req    = 1'b1;
                w_iord       = 1'b1;
                w_mem_write  = bus.mem_ready;
                w_instr_done = bus.mem_ready;
            end
            S_RTYPEEX: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                w_reg_write  = 1'b1;
                w_reg_dst    = 1'b1;
                w_instr_done = 1'b1;
            end
            S_BEQEX: begin
                w_alu_src_a  = 1'b1;
                w_alu_op     = ALUOP_SUB;
                w_pc_src     = PCSRC_ALUOUT;
                w_branch     = 1'b1;
                w_instr_done = 1'b1;
            end
            S_ADDIEX: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = ALUSRCB_IMM;
            end
            S_ADDIWB: begin
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
            end
            S_JEX: begin
                w_pc_src     = PCSRC_JUMP;
                w_pc_write   = 1'b1;
                w_instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    // Enables and pulses are held low for the whole reset cycle
    assign bus.mem_req    = w_mem_req    & ~reset;
    assign bus.mem_write  = w_mem_write  & ~reset;
    assign bus.ir_write   = w_ir_write   & ~reset;
    assign bus.reg_write  = w_reg_write  & ~reset;
    assign bus.pc_en      = (w_pc_write | (w_branch & bus.zero)) & ~reset;
    assign bus.instr_done = w_instr_done & ~reset;
    assign bus.illegal_op = w_illegal_op & ~reset;

    assign bus.iord       = w_iord;
    assign bus.reg_dst    = w_reg_dst;
    assign bus.mem_to_reg = w_mem_to_reg;
    assign bus.alu_src_a  = w_alu_src_a;
    assign bus.alu_src_b  = w_alu_src_b;
    assign bus.alu_op     = w_alu_op;
    assign bus.pc_src     = w_pc_src;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: table-driven, cycle-by-cycle check of the
// multicycle control FSM outputs against per-state expectations.
module tb_multicycle_control;
    import mips_pkg::*;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       pc_en;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic       zero;
        logic       rdy;
        ctrl_t      exp;
        ctrl_t      mask;
        string      name;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    multicycle_control_if bus ();

    multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    vec_t tbl[$];
    vec_t sb[$];

    localparam logic [5:0] OP_BAD  = 6'b111111;
    localparam logic [5:0] OP_BAD2 = 6'b000001;

    // Expected outputs per state, straight from the state table
    function automatic ctrl_t e_fetch(input logic rdy);
        ctrl_t c = '0;
        c.mem_req = 1'b1; c.alu_src_b = 2'b01;
        c.ir_write = rdy; c.pc_en = rdy;
        return c;
    endfunction
    function automatic ctrl_t e_decode(input logic ill);
        ctrl_t c = '0;
        c.alu_src_b = 2'b11; c.illegal_op = ill;
        return c;
    endfunction
    function automatic ctrl_t e_memadr();
        ctrl_t c = '0;
        c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
        return c;
    endfunction
    function automatic ctrl_t e_memrd();
        ctrl_t c = '0;
        c.mem_req = 1'b1; c.iord = 1'b1;
        return c;
    endfunction
    function automatic ctrl_t e_memwb();
        ctrl_t c = '0;
        c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.instr_done = 1'b1;
        return c;
    endfunction
    function automatic ctrl_t e_memwr(input logic rdy);
        ctrl_t c = '0;
        c.mem_req = 1'b1; c.iord = 1'b1;
        c.mem_write = rdy; c.instr_done = rdy;
        return c;
    endfunction
    function automatic ctrl_t e_rtypeex();
        ctrl_t c = '0;
        c.alu_src_a = 1'b1; c.alu_op = 2'b10;
        return c;
    endfunction
    function automatic ctrl_t e_rtypewb();
        ctrl_t c = '0;
        c.reg_write = 1'b1; c.reg_dst = 1'b1; c.instr_done = 1'b1;
        return c;
    endfunction
    function automatic ctrl_t e_beqex(input logic z);
        ctrl_t c = '0;
        c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_src = 2'b01;
        c.pc_en = z; c.instr_done = 1'b1;
        return c;
    endfunction
    function automatic ctrl_t e_addiwb();
        ctrl_t c = '0;
        c.reg_write = 1'b1; c.instr_done = 1'b1;
        return c;
    endfunction
    function automatic ctrl_t e_jex();
        ctrl_t c = '0;
        c.pc_src = 2'b10; c.pc_en = 1'b1; c.instr_done = 1'b1;
        return c;
    endfunction
    // Only the enables/pulses are defined while reset is high
    function automatic ctrl_t m_en();
        ctrl_t c = '0;
        c.mem_req = 1'b1; c.mem_write = 1'b1; c.ir_write = 1'b1;
        c.reg_write = 1'b1; c.pc_en = 1'b1; c.instr_done = 1'b1;
        c.illegal_op = 1'b1;
        return c;
    endfunction

    function automatic vec_t mk(input logic rst, input logic [5:0] op,
                                input logic zero, input logic rdy,
                                input ctrl_t exp, input ctrl_t mask,
                                input string name);
        vec_t v;
        v.rst = rst; v.op = op; v.zero = zero; v.rdy = rdy;
        v.exp = exp; v.mask = mask; v.name = name;
        return v;
    endfunction

    function automatic ctrl_t sample();
        ctrl_t c;
        c.mem_req    = bus.mem_req;
        c.mem_write  = bus.mem_write;
        c.iord       = bus.iord;
        c.ir_write   = bus.ir_write;
        c.reg_write  = bus.reg_write;
        c.reg_dst    = bus.reg_dst;
        c.mem_to_reg = bus.mem_to_reg;
        c.alu_src_a  = bus.alu_src_a;
        c.alu_src_b  = bus.alu_src_b;
        c.alu_op     = bus.alu_op;
        c.pc_src     = bus.pc_src;
        c.pc_en      = bus.pc_en;
        c.instr_done = bus.instr_done;
        c.illegal_op = bus.illegal_op;
        return c;
    endfunction

    // Drive one cycle after the edge, compare mid-cycle
    task automatic step(input vec_t v);
        vec_t  e;
        ctrl_t a;
        @(posedge clk);
        #1;
        reset         = v.rst;
        bus.op        = v.op;
        bus.zero      = v.zero;
        bus.mem_ready = v.rdy;
        sb.push_back(v);
        @(negedge clk);
        e = sb.pop_front();
        a = sample();
        checks++;
        if ((a & e.mask) !== (e.exp & e.mask)) begin
            errors++;
            $display("FAIL %s: got %h want %h (mask %h)", e.name, a, e.exp, e.mask);
        end
    endtask

    initial begin
        ctrl_t full;
        full          = '1;
        bus.op        = OP_BAD;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;

        // reset held for 2 cycles, then release
        tbl.push_back(mk(1, OP_LW,    0, 1, '0,            m_en(), "rst0"));
        tbl.push_back(mk(1, OP_LW,    0, 1, '0,            m_en(), "rst1"));
        tbl.push_back(mk(0, OP_LW,    0, 1, e_fetch(1),    full,   "rst_rel_fetch"));
        // lw with two MEMRD wait cycles; op changes after DECODE are ignored
        tbl.push_back(mk(0, OP_LW,    0, 1, e_decode(0),   full,   "lw_dec"));
        tbl.push_back(mk(0, OP_SW,    0, 1, e_memadr(),    full,   "lw_adr"));
        tbl.push_back(mk(0, OP_SW,    0, 0, e_memrd(),     full,   "lw_rd_wait0"));
        tbl.push_back(mk(0, OP_SW,    0, 0, e_memrd(),     full,   "lw_rd_wait1"));
        tbl.push_back(mk(0, OP_SW,    0, 1, e_memrd(),     full,   "lw_rd_go"));
        tbl.push_back(mk(0, OP_SW,    0, 1, e_memwb(),     full,   "lw_wb"));
        // R-type
        tbl.push_back(mk(0, OP_RTYPE, 0, 1, e_fetch(1),    full,   "r_fetch"));
        tbl.push_back(mk(0, OP_RTYPE, 0, 1, e_decode(0),   full,   "r_dec"));
        tbl.push_back(mk(0, OP_J,     0, 1, e_rtypeex(),   full,   "r_ex"));
        tbl.push_back(mk(0, OP_J,     1, 1, e_rtypewb(),   full,   "r_wb"));
        // beq taken, then not taken
        tbl.push_back(mk(0, OP_BEQ,   0, 1, e_fetch(1),    full,   "beq1_fetch"));
        tbl.push_back(mk(0, OP_BEQ,   0, 1, e_decode(0),   full,   "beq1_dec"));
        tbl.push_back(mk(0, OP_BEQ,   1, 1, e_beqex(1),    full,   "beq1_ex_z1"));
        tbl.push_back(mk(0, OP_BEQ,   1, 1, e_fetch(1),    full,   "beq0_fetch"));
        tbl.push_back(mk(0, OP_BEQ,   1, 1, e_decode(0),   full,   "beq0_dec"));
        tbl.push_back(mk(0, OP_BEQ,   0, 1, e_beqex(0),    full,   "beq0_ex_z0"));
        // addi, with mem_ready low where it must be ignored
        tbl.push_back(mk(0, OP_ADDI,  0, 1, e_fetch(1),    full,   "addi_fetch"));
        tbl.push_back(mk(0, OP_ADDI,  0, 0, e_decode(0),   full,   "addi_dec"));
        tbl.push_back(mk(0, OP_LW,    0, 0, e_memadr(),    full,   "addi_ex"));
        tbl.push_back(mk(0, OP_LW,    0, 0, e_addiwb(),    full,   "addi_wb"));
        // j
        tbl.push_back(mk(0, OP_J,     0, 1, e_fetch(1),    full,   "j_fetch"));
        tbl.push_back(mk(0, OP_J,     0, 1, e_decode(0),   full,   "j_dec"));
        tbl.push_back(mk(0, OP_J,     0, 1, e_jex(),       full,   "j_ex"));
        // sw with one MEMWR wait; op flipped to lw in MEMADR
        tbl.push_back(mk(0, OP_SW,    0, 1, e_fetch(1),    full,   "sw_fetch"));
        tbl.push_back(mk(0, OP_SW,    0, 1, e_decode(0),   full,   "sw_dec"));
        tbl.push_back(mk(0, OP_LW,    0, 1, e_memadr(),    full,   "sw_adr"));
        tbl.push_back(mk(0, OP_LW,    0, 0, e_memwr(0),    full,   "sw_wr_wait"));
        tbl.push_back(mk(0, OP_LW,    0, 1, e_memwr(1),    full,   "sw_wr_go"));
        // FETCH wait: no enables until mem_ready
        tbl.push_back(mk(0, OP_BAD,   0, 0, e_fetch(0),    full,   "fetch_wait0"));
        tbl.push_back(mk(0, OP_BAD,   0, 0, e_fetch(0),    full,   "fetch_wait1"));
        tbl.push_back(mk(0, OP_BAD,   0, 1, e_fetch(1),    full,   "fetch_go"));

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // illegal opcodes: pulse in DECODE, straight back to FETCH
        step(mk(0, OP_BAD,  0, 1, e_decode(1), full, "ill_dec"));
        step(mk(0, OP_BAD,  0, 1, e_fetch(1),  full, "ill_back_fetch"));
        step(mk(0, OP_BAD2, 0, 1, e_decode(1), full, "ill2_dec"));
        step(mk(0, OP_SW,   0, 1, e_fetch(1),  full, "ill2_back_fetch"));

        // reset arrives during a MEMWR wait with mem_ready high
        step(mk(0, OP_SW,   0, 1, e_decode(0), full,   "rstw_dec"));
        step(mk(0, OP_SW,   0, 1, e_memadr(),  full,   "rstw_adr"));
        step(mk(0, OP_SW,   0, 0, e_memwr(0),  full,   "rstw_wr_wait"));
        step(mk(1, OP_SW,   0, 1, '0,          m_en(), "rstw_in_reset"));
        step(mk(0, OP_RTYPE,0, 1, e_fetch(1),  full,   "rstw_fetch"));
        step(mk(0, OP_RTYPE,0, 1, e_decode(0), full,   "rstw_dec_after"));
        step(mk(0, OP_RTYPE,0, 1, e_rtypeex(), full,   "rstw_rex_after"));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle MIPS datapath. Decodes the 6-bit opcode from the instruction register, sequences each instruction through fetch/decode/execute/memory/writeback states, and drives every datapath mux select and write enable. Its `alu_op` output feeds the ALU-control decoder, which combines it with `funct`. Instruction and data memory share one port, and that port has a ready handshake.

## Interface
Parameters:
- none. Opcodes and encodings are fixed constants in `mips_pkg`.

Ports:
- `clk`  in  1  single system clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high
- `op`  in  6  opcode, IR[31:26], valid from DECODE onward
- `zero`  in  1  ALU zero flag, sampled in BEQEX
- `mem_ready`  in  1  memory access completes this cycle
- `mem_req`  out  1  memory access requested
- `mem_write`  out  1  memory write strobe
- `iord`  out  1  0 = address from PC, 1 = address from ALUOut
- `ir_write`  out  1  load instruction register
- `reg_write`  out  1  register-file write
- `reg_dst`  out  1  0 = rt, 1 = rd
- `mem_to_reg`  out  1  0 = ALUOut, 1 = MDR
- `alu_src_a`  out  1  0 = PC, 1 = A
- `alu_src_b`  out  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2
- `alu_op`  out  2  00 = add, 01 = subtract, 10 = use funct
- `pc_src`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- `pc_en`  out  1  PC load enable, equal to pc_write OR (branch AND zero)
- `instr_done`  out  1  one-cycle pulse in the final state of each instruction
- `illegal_op`  out  1  one-cycle pulse in DECODE when `op` is unsupported

## Operation
- Moore FSM with a registered 4-bit state; all outputs decode from the state, except that `mem_ready` gates the memory-state enables and `zero` gates `pc_en`.
- Supported opcodes:
  - R-type: 000000
  - lw: 100011
  - sw: 101011
  - beq: 000100
  - addi: 001000
  - j: 000010
- Outputs not listed for a state are 0.
- FETCH:
  - Always: `mem_req`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_src`=00.
  - Only when `mem_ready`=1: `ir_write`=1 and `pc_en`=1, then go to DECODE.
  - When `mem_ready`=0: stay in FETCH.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00 (computes the branch target). Next state by opcode:
  - lw or sw → MEMADR
  - R-type → RTYPEEX
  - beq → BEQEX
  - addi → ADDIEX
  - j → JEX
  - any other opcode → FETCH, with `illegal_op`=1
- MEMADR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Go to MEMRD for lw, MEMWR for sw.
- MEMRD: `mem_req`=1, `iord`=1. Stay until `mem_ready`, then go to MEMWB.
- MEMWB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0, `instr_done`=1. Go to FETCH.
- MEMWR:
  - Always: `mem_req`=1, `iord`=1.
  - Only when `mem_ready`=1: `mem_write`=1 and `instr_done`=1, then go to FETCH.
  - When `mem_ready`=0: stay in MEMWR.
- RTYPEEX: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10. Go to RTYPEWB.
- RTYPEWB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0, `instr_done`=1. Go to FETCH.
- BEQEX: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_src`=01, `pc_en`=`zero`, `instr_done`=1. Go to FETCH.
- ADDIEX: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Go to ADDIWB.
- ADDIWB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0, `instr_done`=1. Go to FETCH.
- JEX: `pc_src`=10, `pc_en`=1, `instr_done`=1. Go to FETCH.

## Timing
- Reset:
  - On any rising edge with `reset`=1, state becomes FETCH, including mid-instruction or mid-wait.
  - While `reset`=1, `mem_req`, `mem_write`, `ir_write`, `reg_write`, `pc_en`, `instr_done` and `illegal_op` are forced to 0.
  - After reset releases, outputs take their FETCH values.
- Cycle counts with `mem_ready` tied high:
  - lw: 5 cycles
  - sw, R-type, addi: 4 cycles
  - beq, j: 3 cycles
  - illegal opcode: 2 cycles
- Each cycle with `mem_ready`=0 in FETCH, MEMRD or MEMWR adds one cycle. No datapath enable toggles during a wait.
- `op` is sampled only in DECODE; changes to `op` in other states are ignored.
- `zero` is sampled only in BEQEX; `pc_en` follows `zero` combinationally in that state.
- `mem_ready` is ignored outside FETCH, MEMRD and MEMWR.

## Structure
- `mips_pkg` holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J)
  - `alu_op` encodings (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT)
  - `pc_src` and `alu_src_b` encodings
  - the state enumeration
- Single module, no sub-module. Structure it as a next-state block, a state register, and an output decoder.

## Test plan
- `reset`=1 for 2 cycles, then released with `mem_ready`=1 → state FETCH, `ir_write`=1, `pc_en`=1, `alu_src_b`=01; all enables were 0 during reset.
- lw (`op`=100011), `mem_ready` low for 2 cycles in MEMRD → 7 cycles total; `reg_write`=1 with `mem_to_reg`=1 exactly once, then `instr_done`.
- R-type (`op`=000000) → `alu_op`=10 in the third cycle; `reg_write`=1 with `reg_dst`=1 in the fourth.
- beq with `zero`=1, then beq with `zero`=0 → `pc_en`=1 then `pc_en`=0 in BEQEX, `pc_src`=01 both times, 3 cycles each.
- `op`=111111 → `illegal_op` pulses in DECODE, back to FETCH next cycle, no write enables asserted.
- `reset` asserted during a MEMWR wait → state FETCH on the next edge and `mem_write` never pulses.
